uart_receiver: RTL and testbench

- Asynchronous serial receiver; the receive-side counterpart of uart_transmitter.
- Line format: 8N1, idle high, LSB first.
- Oversamples the RX pin with the system clock and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe, and flags framing errors.
- Sits in counter_top between the board RX pin and any consumer, such as a command decoder or loopback to the transmitter.

---
 rtl/uart_receiver.sv | 147 ++++++++++++++
 tb/tb_uart_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver.
// The RX pin is synchronized and then oversampled with the system clock.
// Each bit is sampled at its midpoint. A byte is presented with a one-cycle
// o_valid strobe, and a low stop bit gives a one-cycle o_frame_error strobe.
// i_reset is an asynchronous, active-low reset.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_error,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   clk_cnt;
    logic [CNT_W-1:0]   clk_cnt_next;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_next;
    logic [7:0]         data_next;
    logic               valid_next;
    logic               frame_error_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               rx_s;

    // Synchronizer chain.
    // It is preset to idle-high so that releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign o_busy = (state != IDLE);

    // Register the FSM state, the counters and the output strobes and data.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            o_data        <= 8'h00;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            state         <= state_next;
            clk_cnt       <= clk_cnt_next;
            bit_idx       <= bit_idx_next;
            o_data        <= data_next;
            o_valid       <= valid_next;
            o_frame_error <= frame_error_next;
        end
    end

    // Next-state logic.
    // The start bit is checked at its midpoint; after that, every later sample
    // is taken one full bit period on, which keeps each sample at mid-bit.
    always_comb begin
        state_next       = state;
        clk_cnt_next     = clk_cnt;
        bit_idx_next     = bit_idx;
        data_next        = o_data;
        valid_next       = 1'b0;
        frame_error_next = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_next = '0;
                bit_idx_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_next       = '0;
                    data_next[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_next = '0;
                    if (rx_s) begin
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end

            WAIT_IDLE: begin
                clk_cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver.
// It runs with 16 clocks per bit and a two-stage synchronizer.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_error;
    logic       o_busy;

    int vectors     = 0;
    int miscompares = 0;
    int pcycle      = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } pulse_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap_bits;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    pulse_t     valid_q[$];
    int         ferr_seen = 0;
    vec_t       vecs[6];
    logic [7:0] exp_q[$];

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_error(o_frame_error),
        .o_busy       (o_busy)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Count rising edges so that pulse timing can be measured.
    always @(posedge clk) pcycle++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Record every output strobe on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (o_valid) valid_q.push_back('{o_data, pcycle});
        if (o_frame_error) ferr_seen++;
        if (o_valid || o_frame_error)
            check_output("pulse_exclusive", {31'b0, o_valid & o_frame_error}, 32'd0);
    end

    // Safety net in case the run never reaches its summary line.
    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: actual running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        repeat (CPB) step();
    endtask

    task automatic idle_bits(input int n);
        i_rx = 1'b1;
        repeat (n * CPB) step();
    endtask

    task automatic clear_monitor();
        valid_q.delete();
        ferr_seen = 0;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic stop_bit, output int start_cyc);
        start_cyc = pcycle;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    initial begin
        int busy_cnt;
        int st;
        int lat;
        logic [7:0] d;
        logic bad;
        int gap;
        int n;
        int exp_ferr;

        i_reset = 1'b0;
        i_rx    = 1'b1;

        // Hold reset with a toggling line and check that every output stays at 0.
        for (int c = 0; c < 5; c++) begin
            i_rx = c[0];
            @(negedge clk);
            check_output("reset_outputs", {21'b0, o_data, o_valid, o_frame_error, o_busy}, 32'd0);
        end
        @(posedge clk);
        #1;
        i_rx    = 1'b1;
        i_reset = 1'b1;
        busy_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
        end
        check_output("idle_busy_cycles", busy_cnt, 0);
        step();

        // Table of frames; the back-to-back entries use a gap of zero.
        vecs[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 2, 1, 0, 8'h3C};
        vecs[4] = '{8'h5A, 1'b0, 2, 0, 1, 8'h5A};
        vecs[5] = '{8'h81, 1'b1, 1, 1, 0, 8'h81};

        for (int v = 0; v < 6; v++) begin
            clear_monitor();
            apply_stimulus(vecs[v].data, vecs[v].stop_bit, st);
            idle_bits(vecs[v].gap_bits);
            check_output("vec_valid_count", valid_q.size(), vecs[v].exp_valid);
            check_output("vec_ferr_count", ferr_seen, vecs[v].exp_ferr);
            check_output("vec_data", {24'b0, o_data}, {24'b0, vecs[v].exp_data});
            if (valid_q.size() > 0 && vecs[v].exp_valid == 1) begin
                check_output("vec_pulse_data", {24'b0, valid_q[0].data}, {24'b0, vecs[v].exp_data});
                lat = valid_q[0].cyc - st;
                check_output("vec_latency_window",
                             {31'b0, (lat >= (19 * CPB) / 2) && (lat <= (19 * CPB) / 2 + SYNC + 2)}, 32'd1);
            end
        end

        // A 4-cycle low glitch must be rejected at the mid-start sample.
        clear_monitor();
        busy_cnt = 0;
        i_rx = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            step();
            if (c == 3) i_rx = 1'b1;
        end
        check_output("glitch_busy_seen", {31'b0, busy_cnt > 0}, 32'd1);
        check_output("glitch_busy_short", {31'b0, busy_cnt <= CPB}, 32'd1);
        check_output("glitch_busy_end", {31'b0, o_busy}, 32'd0);
        check_output("glitch_pulses", valid_q.size() + ferr_seen, 0);

        // A bad stop bit followed by a long break gives exactly one error strobe.
        clear_monitor();
        apply_stimulus(8'h55, 1'b0, st);
        i_rx = 1'b0;
        repeat (40 * CPB) step();
        check_output("break_busy", {31'b0, o_busy}, 32'd1);
        check_output("break_ferr_count", ferr_seen, 1);
        check_output("break_valid_count", valid_q.size(), 0);
        idle_bits(2);
        clear_monitor();
        apply_stimulus(8'h81, 1'b1, st);
        idle_bits(2);
        check_output("after_break_count", valid_q.size(), 1);
        if (valid_q.size() > 0)
            check_output("after_break_data", {24'b0, valid_q[0].data}, 32'h81);

        // Reset in the middle of data bit 4 aborts the frame silently.
        clear_monitor();
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        i_rx = d[4];
        repeat (CPB / 2) step();
        i_reset = 1'b0;
        i_rx    = 1'b1;
        #1;
        check_output("midframe_reset", {21'b0, o_data, o_valid, o_frame_error, o_busy}, 32'd0);
        repeat (3) step();
        i_reset = 1'b1;
        idle_bits(2);
        check_output("midframe_idle", {31'b0, o_busy}, 32'd0);
        apply_stimulus(8'hC3, 1'b1, st);
        idle_bits(2);
        check_output("midframe_valid_count", valid_q.size(), 1);
        check_output("midframe_ferr_count", ferr_seen, 0);
        if (valid_q.size() > 0)
            check_output("midframe_data", {24'b0, valid_q[0].data}, 32'hC3);

        // Random frames against the reference model.
        // A good stop bit yields its byte in order, and a bad stop bit yields one error strobe.
        clear_monitor();
        exp_q.delete();
        exp_ferr = 0;
        for (int f = 0; f < 30; f++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            gap = bad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            apply_stimulus(d, ~bad, st);
            idle_bits(gap);
            if (bad) exp_ferr++;
            else exp_q.push_back(d);
        end
        idle_bits(2);
        check_output("rand_valid_count", valid_q.size(), exp_q.size());
        check_output("rand_ferr_count", ferr_seen, exp_ferr);
        n = (valid_q.size() < exp_q.size()) ? valid_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_output("rand_data", {24'b0, valid_q[i].data}, {24'b0, exp_q[i]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
